// File: rtl/sqrt_coproc_ctrl.sv
// Avalon-MM integer square-root coprocessor: restoring digit-by-digit root of a 32-bit
// operand, one root bit per cycle, with 16-bit root and 17-bit remainder results.
module sqrt_coproc_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        busy_out,
   output logic        done_out
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_t;

   typedef struct packed {
      logic [17:0] rem;
      logic [15:0] root;
   } step_t;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [31:0] shift_r;
   logic [17:0] prem_r;
   logic [15:0] proot_r;
   logic [31:0] operand_r;
   logic [15:0] root_r;
   logic [16:0] remainder_r;
   logic        busy_r;
   logic        done_r;
   logic        irq_en_r;
   logic [31:0] readdata_r;

   logic        wr_s;
   logic        start_s;
   logic        status_wr_s;
   step_t       step_s;
   logic [31:0] rd_mux_s;

   // One restoring digit step: bring down two operand bits, try subtracting (4*root+1).
   function automatic step_t digit_step(input logic [17:0] rem,
                                        input logic [15:0] root,
                                        input logic [1:0]  pair);
      step_t       res;
      logic [17:0] rem_sh;
      logic [17:0] trial;
      rem_sh = {rem[15:0], pair};
      trial  = {root, 2'b01};
      if (rem_sh >= trial) begin
         res.rem  = rem_sh - trial;
         res.root = {root[14:0], 1'b1};
      end else begin
         res.rem  = rem_sh;
         res.root = {root[14:0], 1'b0};
      end
      return res;
   endfunction

   // Bus decode and next digit step.
   always_comb begin
      wr_s        = chipselect & ~write_n;
      start_s     = wr_s & (address == 3'd1) & writedata[0] & (state_r == ST_IDLE);
      status_wr_s = wr_s & (address == 3'd2);
      step_s      = digit_step(prem_r, proot_r, shift_r[31:30]);
   end

   // Read multiplexer; CONTROL reads back irq_en with start always 0.
   always_comb begin
      rd_mux_s = 32'd0;
      case (address)
         3'd0:    rd_mux_s = operand_r;
         3'd1:    rd_mux_s = {30'd0, irq_en_r, 1'b0};
         3'd2:    rd_mux_s = {30'd0, done_r, busy_r};
         3'd3:    rd_mux_s = {16'd0, root_r};
         3'd4:    rd_mux_s = {15'd0, remainder_r};
         default: rd_mux_s = 32'd0;
      endcase
   end

   // Control FSM, register file, datapath and registered read port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         shift_r     <= 32'd0;
         prem_r      <= 18'd0;
         proot_r     <= 16'd0;
         operand_r   <= 32'd0;
         root_r      <= 16'd0;
         remainder_r <= 17'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         irq_en_r    <= 1'b0;
         readdata_r  <= 32'd0;
      end else begin
         readdata_r <= rd_mux_s;
         if (wr_s && (address == 3'd1)) begin
            irq_en_r <= writedata[1];
         end
         // OPERAND is frozen while a computation is running.
         if (wr_s && (address == 3'd0) && !busy_r) begin
            operand_r <= writedata;
         end
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  shift_r <= operand_r;
                  prem_r  <= 18'd0;
                  proot_r <= 16'd0;
                  cnt_r   <= 4'd0;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= ST_CALC;
               end else if (status_wr_s) begin
                  done_r <= 1'b0;
               end
            end
            ST_CALC: begin
               shift_r <= {shift_r[29:0], 2'b00};
               prem_r  <= step_s.rem;
               proot_r <= step_s.root;
               cnt_r   <= cnt_r + 4'd1;
               // Completion wins over a concurrent STATUS write.
               if (cnt_r == 4'd15) begin
                  root_r      <= step_s.root;
                  remainder_r <= step_s.rem[16:0];
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
                  state_r     <= ST_IDLE;
               end else if (status_wr_s) begin
                  done_r <= 1'b0;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign readdata = readdata_r;
   assign busy_out = busy_r;
   assign done_out = done_r;
   assign irq      = done_r & irq_en_r;

endmodule

// File: tb/tb_sqrt_coproc_ctrl.sv
// Self-checking bench for sqrt_coproc_ctrl: table vectors, random operands against an
// integer-sqrt search model, and directed multi-cycle corner sequences.
module tb_sqrt_coproc_ctrl;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic        busy_out;
   logic        done_out;

   int          n_vec;
   int          n_err;
   logic [15:0] prev_root;

   typedef struct {
      logic [31:0] op;
      logic [15:0] root;
      logic [16:0] rem;
   } vec_t;

   vec_t vecs [6];

   sqrt_coproc_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .busy_out   (busy_out),
      .done_out   (done_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Largest r with r*r <= x, found by binary search.
   function automatic void ref_sqrt(input logic [31:0] x, output logic [15:0] r,
                                    output logic [16:0] m);
      longint xv, lo, hi, mid;
      xv = x;
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= xv) lo = mid;
         else hi = mid - 1;
      end
      r = lo[15:0];
      mid = xv - lo * lo;
      m = mid[16:0];
   endfunction

   // Called at a negedge; the write lands on the next rising edge; returns at the following negedge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   task automatic run_calc(input logic [31:0] op, input logic [15:0] er,
                           input logic [16:0] erem, input logic ien);
      logic [31:0] d;
      wr(3'd0, op);
      wr(3'd1, {30'd0, ien, 1'b1});
      address = 3'd3;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check($sformatf("busy edge %0d", i), {31'd0, busy_out}, {31'd0, (i < 16)});
         check($sformatf("done edge %0d", i), {31'd0, done_out}, {31'd0, (i == 16)});
         check($sformatf("irq edge %0d", i), {31'd0, irq}, {31'd0, (ien && i == 16)});
         check($sformatf("root held edge %0d", i), readdata, {16'd0, prev_root});
      end
      @(negedge clk);
      check($sformatf("root op=%08h", op), readdata, {16'd0, er});
      rd(3'd4, d);
      check($sformatf("remainder op=%08h", op), d, {15'd0, erem});
      rd(3'd2, d);
      check("status after done", d, 32'h2);
      rd(3'd0, d);
      check("operand readback", d, op);
      prev_root = er;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] op;
      logic [15:0] er;
      logic [16:0] erem;
      logic        seen_done;

      n_vec      = 0;
      n_err      = 0;
      prev_root  = 16'd0;
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;

      vecs[0] = '{32'h00000000, 16'h0000, 17'h00000};
      vecs[1] = '{32'hFFFFFFFF, 16'hFFFF, 17'h1FFFE};
      vecs[2] = '{32'd1000000,  16'd1000, 17'd0};
      vecs[3] = '{32'd99,       16'd9,    17'd18};
      vecs[4] = '{32'hFFFE0001, 16'hFFFF, 17'h00000};
      vecs[5] = '{32'hFFFE0000, 16'hFFFE, 17'h1FFFC};

      repeat (3) @(negedge clk);
      check("reset readdata", readdata, 32'd0);
      check("reset busy", {31'd0, busy_out}, 32'd0);
      check("reset done", {31'd0, done_out}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 8; a++) begin
         rd(a[2:0], d);
         check($sformatf("reset reg %0d", a), d, 32'd0);
      end

      for (int i = 0; i < 6; i++) begin
         run_calc(vecs[i].op, vecs[i].root, vecs[i].rem, 1'b0);
      end

      for (int i = 0; i < 20; i++) begin
         op = $urandom;
         if (i < 5) op = op >> (4 * i + 12);
         ref_sqrt(op, er, erem);
         run_calc(op, er, erem, 1'b0);
      end

      for (int a = 5; a < 8; a++) begin
         wr(a[2:0], 32'hDEADBEEF);
         rd(a[2:0], d);
         check($sformatf("unmapped reg %0d", a), d, 32'd0);
      end

      // Writes of OPERAND and start during CALC are ignored.
      wr(3'd0, 32'd16);
      wr(3'd1, 32'h1);
      repeat (4) @(negedge clk);
      wr(3'd0, 32'd81);
      wr(3'd1, 32'h1);
      check("busy after ignored start", {31'd0, busy_out}, 32'd1);
      repeat (10) @(negedge clk);
      check("done at edge 16 despite restart", {31'd0, done_out}, 32'd1);
      rd(3'd3, d);
      check("root with ignored writes", d, 32'd4);
      rd(3'd0, d);
      check("operand locked", d, 32'd16);
      prev_root = 16'd4;

      // Interrupt behaviour and completion-versus-STATUS-write priority.
      wr(3'd1, 32'h2);
      rd(3'd1, d);
      check("control irq_en readback", d, 32'h2);
      run_calc(32'd2, 16'd1, 17'd1, 1'b1);
      check("irq held after done", {31'd0, irq}, 32'd1);
      wr(3'd2, 32'd0);
      check("irq cleared by status write", {31'd0, irq}, 32'd0);
      check("done cleared by status write", {31'd0, done_out}, 32'd0);
      wr(3'd1, 32'h3);
      repeat (15) @(negedge clk);
      check("done before completion edge", {31'd0, done_out}, 32'd0);
      wr(3'd2, 32'd0);
      check("done wins over status write", {31'd0, done_out}, 32'd1);
      check("irq on completion edge", {31'd0, irq}, 32'd1);
      wr(3'd1, 32'h0);
      check("irq cleared by irq_en write", {31'd0, irq}, 32'd0);
      wr(3'd2, 32'd0);

      // Reset in the middle of a computation.
      wr(3'd1, 32'h2);
      wr(3'd0, 32'd100);
      wr(3'd1, 32'h3);
      address = 3'd3;
      repeat (7) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid reset busy", {31'd0, busy_out}, 32'd0);
      check("mid reset done", {31'd0, done_out}, 32'd0);
      check("mid reset readdata", readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         seen_done = seen_done | done_out | irq;
      end
      check("no done after reset", {31'd0, seen_done}, 32'd0);
      rd(3'd3, d);
      check("root cleared by reset", d, 32'd0);
      rd(3'd1, d);
      check("irq_en cleared by reset", d, 32'd0);
      prev_root = 16'd0;
      run_calc(32'd100, 16'd10, 17'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
